fft_stage_sequencer: RTL and testbench
======================================

# fft_stage_sequencer

Per-stage butterfly scheduler for the 256-point radix-2 FFT. On each `stage_start` from the FFT control FSM it walks all N/2 butterflies of the selected stage, issuing read-address pairs and twiddle indices to the shared sample memory and the butterfly unit. It then replays the matching write-back addresses after the butterfly's fixed pipeline latency and pulses `stage_done` when the stage is fully written back. It sits between the control FSM, the in-place sample RAM and the butterfly datapath.

## Interface
- `N`, 256, FFT length; power of two.
- `LOG2N`, 8, log2(N); width of sample addresses.
- `BF_LATENCY`, 4, butterfly read-accept to result cycles; legal range 1..15.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `stage_start`  in  1  one-cycle request to run stage `stage_idx`.
- `stage_idx`  in  3  stage number 0..LOG2N-1; sampled with `stage_start`.
- `rd_valid`  out  1  read pair/twiddle presented.
- `rd_ready`  in  1  memory grant; the read is accepted on `rd_valid && rd_ready`.
- `rd_addr_a`  out  LOG2N  top-leg sample address.
- `rd_addr_b`  out  LOG2N  bottom-leg sample address.
- `tw_idx`  out  LOG2N-1  twiddle ROM index 0..N/2-1.
- `wr_valid`  out  1  write-back strobe; butterfly result is valid this cycle.
- `wr_addr_a`  out  LOG2N  write-back address, top leg.
- `wr_addr_b`  out  LOG2N  write-back address, bottom leg.
- `busy`  out  1  stage in progress.
- `stage_done`  out  1  one-cycle pulse; last write-back complete.
- `err_overlap`  out  1  sticky; `stage_start` seen while busy.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
  - IDLE→ISSUE on `stage_start`. Latch `s = stage_idx` and clear butterfly counter `k`.
  - ISSUE→DRAIN on acceptance of butterfly k = N/2-1.
  - DRAIN→DONE when the write-back pipe is empty.
  - DONE→IDLE unconditionally.
- Address math, with half = 1<<s:
  - `rd_addr_a = ((k>>s)<<(s+1)) | (k & (half-1))`
  - `rd_addr_b = rd_addr_a + half`
  - `tw_idx = (k & (half-1)) << (LOG2N-1-s)`
  - All results are truncated to port width. No overflow is possible for legal `s`.
- `k` advances only on acceptance. Outputs hold stable while `rd_valid && !rd_ready`.
- The write-back pipe is a BF_LATENCY-deep shift register of {valid, addr_a, addr_b}. It advances every cycle and does not stall.
- `stage_idx` ≥ LOG2N is treated as LOG2N-1.
- `stage_start` while busy (ISSUE/DRAIN/DONE) is ignored and sets `err_overlap`. `err_overlap` clears only on reset.

## Timing
- Reset values: `rd_valid`=0, `wr_valid`=0, `busy`=0, `stage_done`=0, `err_overlap`=0, all address/index outputs 0. State=IDLE, pipe empty.
- `stage_start` sampled high at edge T → `rd_valid`=1 and `busy`=1 from cycle T+1, with k=0.
- `wr_valid` for a read accepted in cycle C appears in cycle C+BF_LATENCY, carrying that read's addresses.
- Unstalled stage: reads in cycles 1..N/2, last write in cycle N/2+BF_LATENCY, `stage_done` in cycle N/2+BF_LATENCY+1.
- `busy` is high through the `stage_done` cycle and low the next cycle.
- A new `stage_start` is accepted in the first IDLE cycle, i.e. the cycle after `stage_done`.
- `rd_valid` drops in the cycle after the last acceptance.
- Asynchronous reset mid-stage flushes the pipe immediately. No `stage_done` is produced and no `wr_valid` for in-flight reads.

## Configuration
- `FFT_SEQ_STALL_CNT_EN` defined: adds output `stall_cycles` (16 bits).
  - Counts cycles with `rd_valid && !rd_ready` in the current stage; saturates at 0xFFFF.
  - Clears when `stage_start` is accepted; holds its value after `stage_done`.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Structure
- `fft_params_pkg` holds N, LOG2N, STAGES and the `seq_state_t` enum (IDLE/ISSUE/DRAIN/DONE).
- One sub-module: `fft_wb_delay`, a parameterised-depth valid+payload shift register for write-back addresses.

## Test plan
- **Stage 0, `rd_ready`=1 (`BF_LATENCY`=4):**
  - k=0 → a=0, b=1, tw=0; k=127 → a=254, b=255, tw=0.
  - 128 reads in cycles 1..128, `stage_done` at cycle 133.
- **Stage 7, unstalled:**
  - k=0 → a=0, b=128, tw=0; k=5 → a=5, b=133, tw=5; k=127 → a=127, b=255, tw=127.
  - Every write-back equals its read pair, delayed exactly 4 cycles.
- **Stage 3, `rd_ready` toggling 1010…:**
  - Outputs held during stalls; k=9 → a=17, b=25, tw=16.
  - Exactly 128 `wr_valid` pulses; `stall_cycles`=127 with the macro defined.
- **Overlap:** second `stage_start` at cycle 50 → ignored, `err_overlap`=1 and stays 1. The stage completes normally with 128 writes.
- **Reset mid-operation:** assert `rst_n`=0 at cycle 60 of stage 2 → all outputs 0 next sample. No `stage_done`; a subsequent `stage_start` runs a clean stage 2.
- **Back-to-back stages 0..7 issued on each IDLE:** 8 `stage_done` pulses; sum of unstalled cycles = 8×(128+4+2).

Source files
------------

// File: rtl/fft_params_pkg.sv
// Shared FFT constants and sequencer state encoding.
package fft_params_pkg;

    localparam int unsigned N       = 256;
    localparam int unsigned LOG2N   = 8;
    localparam int unsigned STAGES  = LOG2N;
    // Width of the stage_idx port; must be able to hold LOG2N-1.
    localparam int unsigned STAGE_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/fft_wb_delay.sv
// Fixed-latency valid+payload shift register carrying write-back addresses.
// Advances every cycle, never stalls. Empty slots hold zero payload, so the
// output payload reads zero whenever out_valid is low.
module fft_wb_delay #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             empty_next
);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];

    // Shift one slot towards the output; slot 0 takes the new entry.
    always_comb begin
        vld_d = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            data_d[i] = '0;
        end
        vld_d[0]  = in_valid;
        data_d[0] = in_valid ? in_data : '0;
        for (int i = 1; i < int'(DEPTH); i++) begin
            vld_d[i]  = vld_q[i-1];
            data_d[i] = data_q[i-1];
        end
    end

    // Pipe will hold nothing after this edge: only the output slot (if any) is live.
    always_comb begin
        empty_next = !in_valid;
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            if (vld_q[i]) begin
                empty_next = 1'b0;
            end
        end
    end

    // Pipe registers; asynchronous reset flushes all in-flight entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Radix-2 FFT per-stage butterfly scheduler: issues read pairs and twiddle
// indices for all N/2 butterflies of one stage, replays write-back addresses
// BF_LATENCY cycles after each accepted read, then pulses stage_done.
// Optional: define FFT_SEQ_STALL_CNT_EN to add the stall_cycles counter port.
module fft_stage_sequencer
    import fft_params_pkg::*;
#(
    parameter int unsigned BF_LATENCY = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stage_start,
    input  logic [STAGE_W-1:0] stage_idx,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [LOG2N-1:0]   rd_addr_a,
    output logic [LOG2N-1:0]   rd_addr_b,
    output logic [LOG2N-2:0]   tw_idx,
    output logic               wr_valid,
    output logic [LOG2N-1:0]   wr_addr_a,
    output logic [LOG2N-1:0]   wr_addr_b,
    output logic               busy,
    output logic               stage_done,
    output logic               err_overlap
`ifdef FFT_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cycles
`endif
);

    localparam logic [LOG2N-2:0] K_LAST = '1;

    seq_state_t         state_q, state_d;
    logic [STAGE_W-1:0] s_q, s_d;
    logic [LOG2N-2:0]   k_q, k_d;
    logic               err_q, err_d;
    logic               accept;
    logic               pipe_empty_next;
    logic [STAGE_W-1:0] s_in;
    logic [LOG2N-1:0]   k_ext, half, low, addr_a, addr_b;
    logic [LOG2N-2:0]   tw;
    logic [2*LOG2N-1:0] wr_data;

    assign accept = (state_q == ISSUE) && rd_ready;
    // Out-of-range stage numbers run the last stage.
    assign s_in   = (32'(stage_idx) >= LOG2N) ? STAGE_W'(LOG2N - 1) : stage_idx;

    // Butterfly k of stage s: legs are half apart inside groups of 2*half.
    always_comb begin
        k_ext  = {1'b0, k_q};
        half   = LOG2N'(1) << s_q;
        low    = k_ext & (half - 1'b1);
        addr_a = ((k_ext >> s_q) << ({1'b0, s_q} + 4'd1)) | low;
        addr_b = addr_a + half;
        tw     = (LOG2N-1)'(low) << (STAGE_W'(LOG2N - 1) - s_q);
    end

    // Next-state logic for the stage walk and the sticky overlap flag.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (stage_start) begin
                    state_d = ISSUE;
                    s_d     = s_in;
                    k_d     = '0;
                end
            end
            ISSUE: begin
                if (accept) begin
                    k_d = k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pipe_empty_next) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (stage_start && (state_q != IDLE)) begin
            err_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            err_q   <= err_d;
        end
    end

    fft_wb_delay #(
        .DEPTH (BF_LATENCY),
        .WIDTH (2 * LOG2N)
    ) u_wb_delay (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (accept),
        .in_data    ({addr_a, addr_b}),
        .out_valid  (wr_valid),
        .out_data   (wr_data),
        .empty_next (pipe_empty_next)
    );

    assign rd_valid    = (state_q == ISSUE);
    assign rd_addr_a   = rd_valid ? addr_a : '0;
    assign rd_addr_b   = rd_valid ? addr_b : '0;
    assign tw_idx      = rd_valid ? tw : '0;
    assign wr_addr_a   = wr_data[2*LOG2N-1:LOG2N];
    assign wr_addr_b   = wr_data[LOG2N-1:0];
    assign busy        = (state_q != IDLE);
    assign stage_done  = (state_q == DONE);
    assign err_overlap = err_q;

`ifdef FFT_SEQ_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of refused reads; cleared on an accepted stage_start.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) && stage_start) begin
            stall_d = '0;
        end else if ((state_q == ISSUE) && !rd_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer against an arithmetic
// butterfly-schedule model with a write-back expectation queue.
module tb_fft_stage_sequencer;

    localparam int HALF_N = 128;
    localparam int BF_LAT = 4;
    localparam int LIMIT  = 2000;

    typedef struct {
        int a;
        int b;
        int due;
    } wb_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stage_start = 1'b0;
    logic [2:0] stage_idx = '0;
    logic       rd_ready = 1'b0;
    logic       rd_valid, wr_valid, busy, stage_done, err_overlap;
    logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [6:0] tw_idx;
`ifdef FFT_SEQ_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit err_model = 1'b0;
    int spot [6][5] = '{'{0, 0, 0, 1, 0}, '{0, 127, 254, 255, 0}, '{7, 0, 0, 128, 0},
                        '{7, 5, 5, 133, 5}, '{7, 127, 127, 255, 127}, '{3, 9, 17, 25, 16}};

    fft_stage_sequencer #(
        .BF_LATENCY (BF_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stage_start  (stage_start),
        .stage_idx    (stage_idx),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .tw_idx       (tw_idx),
        .wr_valid     (wr_valid),
        .wr_addr_a    (wr_addr_a),
        .wr_addr_b    (wr_addr_b),
        .busy         (busy),
        .stage_done   (stage_done),
        .err_overlap  (err_overlap)
`ifdef FFT_SEQ_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Butterfly k of stage s: group of 2*half, position inside the group.
    function automatic void bf_model(input int s, input int k, output int a, output int b,
                                     output int tw);
        int half;
        int grp;
        int pos;
        half = 1 << s;
        grp  = k / half;
        pos  = k % half;
        a    = grp * 2 * half + pos;
        b    = a + half;
        tw   = pos * (HALF_N / half);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_wr_valid"}, wr_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_stage_done"}, stage_done, 0);
        chk({tag, "_err_overlap"}, err_overlap, 0);
        chk({tag, "_rd_addr_a"}, rd_addr_a, 0);
        chk({tag, "_rd_addr_b"}, rd_addr_b, 0);
        chk({tag, "_tw_idx"}, tw_idx, 0);
        chk({tag, "_wr_addr_a"}, wr_addr_a, 0);
        chk({tag, "_wr_addr_b"}, wr_addr_b, 0);
    endtask

    // Runs one stage from the current (idle) cycle. mode: 0 ready, 1 toggling, 2 random.
    // ovl_at / rst_at: cycle of an overlapping start / mid-stage reset (0 = none).
    task automatic run_stage(input int s, input int mode, input int ovl_at, input int rst_at,
                             output int done_cyc);
        int  kexp, exp_done, writes, stalls, a, b, tw, c;
        bit  got_done, rdy;
        wb_t q[$];
        wb_t e;
        kexp = 0; exp_done = -1; writes = 0; stalls = 0; got_done = 1'b0; done_cyc = -1;
        stage_start = 1'b1;
        stage_idx   = 3'(s);
        @(negedge clk);
        stage_start = 1'b0;
        for (c = 1; c <= LIMIT && !got_done; c++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = c[0];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            rd_ready = rdy;
            if (c == ovl_at) begin
                stage_start = 1'b1;
                stage_idx   = 3'(s ^ 1);
            end
            #1;
            chk("busy", busy, 1);
            chk("err_overlap", err_overlap, err_model);
            chk("rd_valid", rd_valid, kexp < HALF_N);
            if (kexp < HALF_N) begin
                bf_model(s, kexp, a, b, tw);
                chk("rd_addr_a", rd_addr_a, a);
                chk("rd_addr_b", rd_addr_b, b);
                chk("tw_idx", tw_idx, tw);
                for (int i = 0; i < 6; i++) begin
                    if (spot[i][0] == s && spot[i][1] == kexp) begin
                        chk("spot_a", rd_addr_a, spot[i][2]);
                        chk("spot_b", rd_addr_b, spot[i][3]);
                        chk("spot_tw", tw_idx, spot[i][4]);
                    end
                end
                if (rdy) begin
                    q.push_back('{a, b, c + BF_LAT});
                    kexp++;
                    if (kexp == HALF_N) exp_done = c + BF_LAT + 1;
                end else begin
                    stalls++;
                end
            end
            if (q.size() > 0 && q[0].due == c) begin
                e = q.pop_front();
                chk("wr_valid", wr_valid, 1);
                chk("wr_addr_a", wr_addr_a, e.a);
                chk("wr_addr_b", wr_addr_b, e.b);
                writes++;
            end else begin
                chk("wr_valid", wr_valid, 0);
            end
            chk("stage_done", stage_done, c == exp_done);
            if (stage_done === 1'b1) begin
                got_done = 1'b1;
                done_cyc = c;
            end
            if (c == ovl_at) err_model = 1'b1;
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk_all_zero("reset_mid");
                err_model = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                repeat (BF_LAT + 2) begin
                    @(negedge clk);
                    #1;
                    chk("post_rst_wr_valid", wr_valid, 0);
                    chk("post_rst_stage_done", stage_done, 0);
                    chk("post_rst_busy", busy, 0);
                end
                return;
            end
            @(negedge clk);
            stage_start = 1'b0;
        end
        #1;
        chk("done_seen", got_done, 1);
        chk("done_cycle", done_cyc, exp_done);
        chk("write_count", writes, HALF_N);
        chk("idle_busy", busy, 0);
        chk("idle_rd_valid", rd_valid, 0);
        chk("idle_stage_done", stage_done, 0);
`ifdef FFT_SEQ_STALL_CNT_EN
        chk("stall_cycles", stall_cycles, stalls);
        if (mode == 1) chk("stall_toggle", stall_cycles, 127);
`endif
    endtask

    initial begin
        int d;
        int total;
        int ndone;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk_all_zero("after_reset");
`ifdef FFT_SEQ_STALL_CNT_EN
        chk("reset_stall", stall_cycles, 0);
`endif
        run_stage(0, 0, 0, 0, d);
        chk("stage0_done_cycle", d, 133);
        run_stage(7, 0, 0, 0, d);
        run_stage(3, 1, 0, 0, d);
        run_stage(5, 2, 50, 0, d);
        run_stage(2, 0, 0, 60, d);
        run_stage(2, 0, 0, 0, d);
        total = 0;
        ndone = 0;
        for (int s = 0; s < 8; s++) begin
            run_stage(s, 0, 0, 0, d);
            total += d + 1;
            if (d > 0) ndone++;
        end
        chk("b2b_done_pulses", ndone, 8);
        chk("b2b_cycles", total, 8 * (HALF_N + BF_LAT + 2));
        repeat (3) run_stage(int'($urandom_range(0, 7)), 2, 0, 0, d);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
